reservation_station: RTL and testbench

//  Holds decoded ALU-class instructions (CAL, CALI, LUI, AUIPC, B, JAL, JALR) until both operands are known.

---
 rtl/reservation_station_pkg.sv | 37 +++
 rtl/rs_pick.sv | 30 +++
 rtl/reservation_station.sv | 119 +++++++++++
 tb/tb_reservation_station.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/reservation_station_pkg.sv
// Shared types for the ALU reservation station: entry layout, broadcast bus,
// and the tag-match wakeup helper used by both issue and resident entries.
package reservation_station_pkg;
    localparam int RS_SIZE  = 16;
    localparam int RS_IDX_W = 4;
    localparam int ROB_W    = 4;
    localparam int XLEN     = 32;

    typedef struct packed {
        logic [6:0]       opcode;
        logic [2:0]       funct3;
        logic             funct7;
        logic [XLEN-1:0]  val1;
        logic             has_dep1;
        logic [ROB_W-1:0] dep1;
        logic [XLEN-1:0]  val2;
        logic             has_dep2;
        logic [ROB_W-1:0] dep2;
        logic [XLEN-1:0]  imm;
        logic [ROB_W-1:0] rob_pos;
        logic [XLEN-1:0]  pc;
    } rs_entry_t;

    typedef struct packed {
        logic             done;
        logic [ROB_W-1:0] rob_pos;
        logic [XLEN-1:0]  val;
    } bc_t;

    // Returns {has_dep, val} after snooping both buses; ALU wins if both match.
    function automatic logic [XLEN:0] wake(input logic has, input logic [ROB_W-1:0] dep,
                                           input logic [XLEN-1:0] val, input bc_t a, input bc_t l);
        if (has && a.done && a.rob_pos == dep) return {1'b0, a.val};
        if (has && l.done && l.rob_pos == dep) return {1'b0, l.val};
        return {has, val};
    endfunction
endpackage

// File: rtl/rs_pick.sv
// Lowest-index priority encoders: first free slot for issue, first ready slot for dispatch.
module rs_pick #(
    parameter int N     = 16,
    parameter int IDX_W = 4
) (
    input  logic [N-1:0]     busy,
    input  logic [N-1:0]     ready,
    output logic [IDX_W-1:0] free_idx,
    output logic             free_found,
    output logic [IDX_W-1:0] rdy_idx,
    output logic             rdy_found
);
    always_comb begin
        free_idx   = '0;
        free_found = 1'b0;
        rdy_idx    = '0;
        rdy_found  = 1'b0;
        // Scan downwards so the lowest index is the last one written.
        for (int i = N - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                free_idx   = IDX_W'(i);
                free_found = 1'b1;
            end
            if (ready[i]) begin
                rdy_idx   = IDX_W'(i);
                rdy_found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/reservation_station.sv
// ALU reservation station: holds issued ops until both operands resolve via
// result-bus snooping, then dispatches the lowest-index ready entry each cycle.
module reservation_station
    import reservation_station_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic                rollback,
    input  logic                iss_valid,
    input  logic [6:0]          iss_opcode,
    input  logic [2:0]          iss_funct3,
    input  logic                iss_funct7,
    input  logic [XLEN-1:0]     iss_val1,
    input  logic                iss_has_dep1,
    input  logic [ROB_W-1:0]    iss_dep1,
    input  logic [XLEN-1:0]     iss_val2,
    input  logic                iss_has_dep2,
    input  logic [ROB_W-1:0]    iss_dep2,
    input  logic [XLEN-1:0]     iss_imm,
    input  logic [ROB_W-1:0]    iss_rob_pos,
    input  logic [XLEN-1:0]     iss_pc,
    input  logic                alu_bc_done,
    input  logic [ROB_W-1:0]    alu_bc_rob_pos,
    input  logic [XLEN-1:0]     alu_bc_val,
    input  logic                lsb_bc_done,
    input  logic [ROB_W-1:0]    lsb_bc_rob_pos,
    input  logic [XLEN-1:0]     lsb_bc_val,
    output logic                rs_full,
    output logic                alu_en,
    output logic [6:0]          alu_opcode,
    output logic [2:0]          alu_funct3,
    output logic                alu_funct7,
    output logic [XLEN-1:0]     alu_val1,
    output logic [XLEN-1:0]     alu_val2,
    output logic [XLEN-1:0]     alu_imm,
    output logic [XLEN-1:0]     alu_pc,
    output logic [ROB_W-1:0]    alu_rob_pos
);
    bc_t alu_bc, lsb_bc;
    assign alu_bc = {alu_bc_done, alu_bc_rob_pos, alu_bc_val};
    assign lsb_bc = {lsb_bc_done, lsb_bc_rob_pos, lsb_bc_val};

    logic [RS_SIZE-1:0]  busy;
    logic [RS_SIZE-1:0]  ready;
    rs_entry_t           ent [RS_SIZE];
    rs_entry_t           iss_ent;
    logic [RS_IDX_W-1:0] free_idx, rdy_idx;
    logic                free_found, rdy_found;

    for (genvar g = 0; g < RS_SIZE; g++) begin : g_ready
        assign ready[g] = busy[g] & ~ent[g].has_dep1 & ~ent[g].has_dep2;
    end

    rs_pick #(.N(RS_SIZE), .IDX_W(RS_IDX_W)) u_pick (
        .busy       (busy),
        .ready      (ready),
        .free_idx   (free_idx),
        .free_found (free_found),
        .rdy_idx    (rdy_idx),
        .rdy_found  (rdy_found)
    );

    assign rs_full = ~free_found;

    // Incoming op with any same-cycle broadcast already folded in.
    always_comb begin
        iss_ent         = '0;
        iss_ent.opcode  = iss_opcode;
        iss_ent.funct3  = iss_funct3;
        iss_ent.funct7  = iss_funct7;
        iss_ent.dep1    = iss_dep1;
        iss_ent.dep2    = iss_dep2;
        iss_ent.imm     = iss_imm;
        iss_ent.rob_pos = iss_rob_pos;
        iss_ent.pc      = iss_pc;
        {iss_ent.has_dep1, iss_ent.val1} = wake(iss_has_dep1, iss_dep1, iss_val1, alu_bc, lsb_bc);
        {iss_ent.has_dep2, iss_ent.val2} = wake(iss_has_dep2, iss_dep2, iss_val2, alu_bc, lsb_bc);
    end

    always_ff @(posedge clk) begin
        if (rst || rollback) begin
            busy        <= '0;
            alu_en      <= 1'b0;
            alu_opcode  <= '0;
            alu_funct3  <= '0;
            alu_funct7  <= 1'b0;
            alu_val1    <= '0;
            alu_val2    <= '0;
            alu_imm     <= '0;
            alu_pc      <= '0;
            alu_rob_pos <= '0;
        end else if (rdy) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (busy[i]) begin
                    {ent[i].has_dep1, ent[i].val1} <= wake(ent[i].has_dep1, ent[i].dep1, ent[i].val1, alu_bc, lsb_bc);
                    {ent[i].has_dep2, ent[i].val2} <= wake(ent[i].has_dep2, ent[i].dep2, ent[i].val2, alu_bc, lsb_bc);
                end
            end
            alu_en <= rdy_found;
            if (rdy_found) begin
                busy[rdy_idx] <= 1'b0;
                alu_opcode    <= ent[rdy_idx].opcode;
                alu_funct3    <= ent[rdy_idx].funct3;
                alu_funct7    <= ent[rdy_idx].funct7;
                alu_val1      <= ent[rdy_idx].val1;
                alu_val2      <= ent[rdy_idx].val2;
                alu_imm       <= ent[rdy_idx].imm;
                alu_pc        <= ent[rdy_idx].pc;
                alu_rob_pos   <= ent[rdy_idx].rob_pos;
            end
            // free_idx is never busy, so it cannot collide with the dispatch slot.
            if (iss_valid && free_found) begin
                busy[free_idx] <= 1'b1;
                ent[free_idx]  <= iss_ent;
            end
        end
    end
endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station: issue/wakeup/dispatch, full, rollback, freeze.
module tb_reservation_station;
    logic        clk = 1'b0;
    logic        rst, rdy, rollback;
    logic        iss_valid;
    logic [6:0]  iss_opcode;
    logic [2:0]  iss_funct3;
    logic        iss_funct7;
    logic [31:0] iss_val1, iss_val2, iss_imm, iss_pc;
    logic        iss_has_dep1, iss_has_dep2;
    logic [3:0]  iss_dep1, iss_dep2, iss_rob_pos;
    logic        alu_bc_done, lsb_bc_done;
    logic [3:0]  alu_bc_rob_pos, lsb_bc_rob_pos;
    logic [31:0] alu_bc_val, lsb_bc_val;
    logic        rs_full, alu_en;
    logic [6:0]  alu_opcode;
    logic [2:0]  alu_funct3;
    logic        alu_funct7;
    logic [31:0] alu_val1, alu_val2, alu_imm, alu_pc;
    logic [3:0]  alu_rob_pos;

    int n_asrt = 0;
    int n_fail = 0;

    reservation_station dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
        .iss_valid(iss_valid), .iss_opcode(iss_opcode), .iss_funct3(iss_funct3),
        .iss_funct7(iss_funct7), .iss_val1(iss_val1), .iss_has_dep1(iss_has_dep1),
        .iss_dep1(iss_dep1), .iss_val2(iss_val2), .iss_has_dep2(iss_has_dep2),
        .iss_dep2(iss_dep2), .iss_imm(iss_imm), .iss_rob_pos(iss_rob_pos), .iss_pc(iss_pc),
        .alu_bc_done(alu_bc_done), .alu_bc_rob_pos(alu_bc_rob_pos), .alu_bc_val(alu_bc_val),
        .lsb_bc_done(lsb_bc_done), .lsb_bc_rob_pos(lsb_bc_rob_pos), .lsb_bc_val(lsb_bc_val),
        .rs_full(rs_full), .alu_en(alu_en), .alu_opcode(alu_opcode), .alu_funct3(alu_funct3),
        .alu_funct7(alu_funct7), .alu_val1(alu_val1), .alu_val2(alu_val2), .alu_imm(alu_imm),
        .alu_pc(alu_pc), .alu_rob_pos(alu_rob_pos)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_iss();
        iss_valid = 0; iss_opcode = 0; iss_funct3 = 0; iss_funct7 = 0;
        iss_val1 = 0; iss_has_dep1 = 0; iss_dep1 = 0;
        iss_val2 = 0; iss_has_dep2 = 0; iss_dep2 = 0;
        iss_imm = 0; iss_rob_pos = 0; iss_pc = 0;
    endtask

    task automatic clear_bc();
        alu_bc_done = 0; alu_bc_rob_pos = 0; alu_bc_val = 0;
        lsb_bc_done = 0; lsb_bc_rob_pos = 0; lsb_bc_val = 0;
    endtask

    task automatic issue(input logic [6:0] op, input logic f7, input logic [31:0] v1,
                         input logic hd1, input logic [3:0] d1, input logic [31:0] v2,
                         input logic hd2, input logic [3:0] d2, input logic [31:0] imm,
                         input logic [3:0] rob, input logic [31:0] pc);
        iss_valid = 1; iss_opcode = op; iss_funct3 = 3'd0; iss_funct7 = f7;
        iss_val1 = v1; iss_has_dep1 = hd1; iss_dep1 = d1;
        iss_val2 = v2; iss_has_dep2 = hd2; iss_dep2 = d2;
        iss_imm = imm; iss_rob_pos = rob; iss_pc = pc;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1; rdy = 1; rollback = 0;
        clear_iss(); clear_bc();
        @(negedge clk);
        tick(); tick();
        chk("rst_alu_en", alu_en, 0);
        chk("rst_full", rs_full, 0);
        chk("rst_val1", alu_val1, 0);
        chk("rst_rob", alu_rob_pos, 0);
        rst = 0;

        // 1: ADDI with no dependencies
        issue(7'h13, 0, 32'd5, 0, 0, 0, 0, 0, 32'd7, 4'd3, 32'h100);
        tick(); clear_iss();
        chk("t1_latency", alu_en, 0);
        tick();
        chk("t1_en", alu_en, 1);
        chk("t1_val1", alu_val1, 32'd5);
        chk("t1_imm", alu_imm, 32'd7);
        chk("t1_rob", alu_rob_pos, 4'd3);
        chk("t1_op", alu_opcode, 7'h13);
        chk("t1_pc", alu_pc, 32'h100);
        tick();
        chk("t1_drop", alu_en, 0);

        // 2: ADD waiting on tag 2, woken by ALU broadcast 3 cycles later
        issue(7'h33, 0, 0, 1, 4'd2, 32'd3, 0, 0, 0, 4'd4, 32'h200);
        tick(); clear_iss();
        tick(); tick();
        chk("t2_waiting", alu_en, 0);
        alu_bc_done = 1; alu_bc_rob_pos = 4'd2; alu_bc_val = 32'h10;
        tick(); clear_bc();
        chk("t2_wake_lat", alu_en, 0);
        tick();
        chk("t2_en", alu_en, 1);
        chk("t2_val1", alu_val1, 32'h10);
        chk("t2_val2", alu_val2, 32'd3);
        chk("t2_rob", alu_rob_pos, 4'd4);
        tick();

        // 3: same-cycle LSB wakeup of rs2 at issue
        issue(7'h33, 1, 32'd7, 0, 0, 0, 1, 4'd5, 0, 4'd6, 32'h300);
        lsb_bc_done = 1; lsb_bc_rob_pos = 4'd5; lsb_bc_val = 32'hAB;
        tick(); clear_iss(); clear_bc();
        chk("t3_latency", alu_en, 0);
        tick();
        chk("t3_en", alu_en, 1);
        chk("t3_val2", alu_val2, 32'hAB);
        chk("t3_val1", alu_val1, 32'd7);
        chk("t3_f7", alu_funct7, 1);
        chk("t3_rob", alu_rob_pos, 4'd6);
        tick();

        // 4: fill all 16 entries, drop a 17th, then release them all
        for (int i = 0; i < 16; i++) begin
            chk("t4_not_full", rs_full, 0);
            issue(7'h33, 0, 0, 1, 4'd7, i, 0, 0, 0, i[3:0], 0);
            tick();
        end
        chk("t4_full", rs_full, 1);
        $display("note: issuing into a full station, input must be dropped");
        issue(7'h33, 0, 0, 0, 0, 32'hDEAD, 0, 0, 0, 4'd9, 0);
        tick(); clear_iss();
        chk("t4_still_full", rs_full, 1);
        chk("t4_no_dispatch", alu_en, 0);
        alu_bc_done = 1; alu_bc_rob_pos = 4'd7; alu_bc_val = 32'h100;
        tick(); clear_bc();
        chk("t4_wake_lat", alu_en, 0);
        for (int i = 0; i < 16; i++) begin
            tick();
            chk("t4_en", alu_en, 1);
            chk("t4_order_rob", alu_rob_pos, i);
            chk("t4_val2", alu_val2, i);
            chk("t4_val1", alu_val1, 32'h100);
            chk("t4_free", rs_full, 0);
        end
        tick();
        chk("t4_no_17th", alu_en, 0);

        // 5: rollback with one ready and three waiting entries
        for (int i = 1; i <= 3; i++) begin
            issue(7'h33, 0, 0, 1, 4'd1, 0, 0, 0, 0, i[3:0], 0);
            tick();
        end
        issue(7'h13, 0, 32'h44, 0, 0, 0, 0, 0, 0, 4'd4, 0);
        tick(); clear_iss();
        chk("t5_full_before", rs_full, 0);
        rollback = 1;
        tick(); rollback = 0;
        chk("t5_en", alu_en, 0);
        chk("t5_full", rs_full, 0);
        chk("t5_rob", alu_rob_pos, 0);
        alu_bc_done = 1; alu_bc_rob_pos = 4'd1; alu_bc_val = 32'h5;
        tick(); clear_bc();
        tick();
        chk("t5_no_old_a", alu_en, 0);
        tick();
        chk("t5_no_old_b", alu_en, 0);

        // 6: freeze with rdy=0 while a dispatch is on the outputs
        issue(7'h13, 0, 32'h66, 0, 0, 0, 0, 0, 0, 4'd6, 0);
        tick();
        issue(7'h13, 0, 32'h88, 0, 0, 0, 0, 0, 0, 4'd8, 0);
        tick(); clear_iss();
        chk("t6_en", alu_en, 1);
        chk("t6_rob", alu_rob_pos, 4'd6);
        rdy = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t6_frz_en", alu_en, 1);
            chk("t6_frz_rob", alu_rob_pos, 4'd6);
            chk("t6_frz_val1", alu_val1, 32'h66);
        end
        rdy = 1;
        tick();
        chk("t6_resume_en", alu_en, 1);
        chk("t6_resume_rob", alu_rob_pos, 4'd8);
        chk("t6_resume_val1", alu_val1, 32'h88);
        tick();
        chk("t6_idle", alu_en, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end
endmodule
